// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and load/store requesters.
// Data requests take priority; a run of data grants is capped so a pending fetch cannot starve.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int MEM_LAT     = 1,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_ack_o,
    output logic [31:0]       i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_ack_o,
    output logic [31:0]       d_rdata_o,
    output logic              m_en_o,
    output logic              m_we_o,
    output logic [ADDR_W-3:0] m_addr_o,
    output logic [31:0]       m_wdata_o,
    input  logic [31:0]       m_rdata_i,
    output logic              busy_o
);

    // state   | meaning
    // S_IDLE  | no access in flight, grant decided at the end of this cycle
    // S_ISSUE | memory strobe cycle for the latched access
    // S_WAIT  | counting down the memory read latency
    // S_RESP  | owner's ack pulse, all requests ignored
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STK_W = $clog2(MAX_DSTREAK + 1);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [STK_W-1:0]    dstreak_q, dstreak_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [31:0]         i_rdata_q, i_rdata_d;
    logic [31:0]         d_rdata_q, d_rdata_d;
    logic                m_en_q, m_en_d;
    logic                m_we_q, m_we_d;
    logic [ADDR_W-3:0]   m_addr_q, m_addr_d;
    logic [31:0]         m_wdata_q, m_wdata_d;
    logic                busy_q, busy_d;
    logic                data_wins;

    // Byte offsets are dropped: the memory is word addressed and alignment is not checked.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr_i[1:0], d_addr_i[1:0]};

    assign data_wins = d_req_i && !(i_req_i && (dstreak_q == STK_W'(MAX_DSTREAK)));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        dstreak_d = dstreak_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        m_en_d    = 1'b0;
        m_we_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_req_i || i_req_i) begin
                    state_d = S_ISSUE;
                    m_en_d  = 1'b1;
                    if (data_wins) begin
                        owner_d   = 1'b1;
                        we_d      = d_we_i;
                        m_we_d    = d_we_i;
                        m_addr_d  = d_addr_i[ADDR_W-1:2];
                        m_wdata_d = d_wdata_i;
                        if (!i_req_i) begin
                            dstreak_d = '0;
                        end else if (dstreak_q != STK_W'(MAX_DSTREAK)) begin
                            dstreak_d = dstreak_q + 1'b1;
                        end
                    end else begin
                        owner_d   = 1'b0;
                        we_d      = 1'b0;
                        m_addr_d  = i_addr_i[ADDR_W-1:2];
                        dstreak_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(MEM_LAT - 1);
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    if (owner_q) begin
                        d_ack_d = 1'b1;
                        if (!we_q) d_rdata_d = m_rdata_i;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            dstreak_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            dstreak_q <= dstreak_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            busy_q    <= busy_d;
        end
    end

    assign i_ack_o   = i_ack_q;
    assign d_ack_o   = d_ack_q;
    assign i_rdata_o = i_rdata_q;
    assign d_rdata_o = d_rdata_q;
    assign m_en_o    = m_en_q;
    assign m_we_o    = m_we_q;
    assign m_addr_o  = m_addr_q;
    assign m_wdata_o = m_wdata_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: MEM_LAT=1 instance with scoreboarded acks, plus a MEM_LAT=3
// instance for latency; both backed by simple pipelined memory models.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic i_ack, d_ack, m_en, m_we, busy;
    logic [31:0] i_rdata, d_rdata, m_wdata, m_rdata;
    logic [29:0] m_addr;

    logic b_i_req;
    logic [31:0] b_i_addr;
    logic b_d_req = 1'b0;
    logic b_d_we = 1'b0;
    logic [31:0] b_d_addr = 32'h0;
    logic [31:0] b_d_wdata = 32'h0;
    logic b_i_ack, b_d_ack, b_m_en, b_m_we, b_busy;
    logic [31:0] b_i_rdata, b_d_rdata, b_m_wdata, b_m_rdata;
    logic [29:0] b_m_addr;

    mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(1), .MAX_DSTREAK(4)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .i_req_i(i_req), .i_addr_i(i_addr), .i_ack_o(i_ack), .i_rdata_o(i_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ack_o(d_ack), .d_rdata_o(d_rdata),
        .m_en_o(m_en), .m_we_o(m_we), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_rdata_i(m_rdata), .busy_o(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(3), .MAX_DSTREAK(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .i_req_i(b_i_req), .i_addr_i(b_i_addr), .i_ack_o(b_i_ack), .i_rdata_o(b_i_rdata),
        .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata),
        .d_ack_o(b_d_ack), .d_rdata_o(b_d_rdata),
        .m_en_o(b_m_en), .m_we_o(b_m_we), .m_addr_o(b_m_addr), .m_wdata_o(b_m_wdata),
        .m_rdata_i(b_m_rdata), .busy_o(b_busy)
    );

    // Memory models: read data is valid only MEM_LAT cycles after the strobe, garbage otherwise.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    bit init_done = 1'b0;
    logic [31:0] rd_a = 32'hBAD0_BAD0;
    logic [31:0] pb0 = 32'hBAD0_BAD0;
    logic [31:0] pb1 = 32'hBAD0_BAD0;
    logic [31:0] pb2 = 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 32'hA500_0000 | 32'(i);
                mem_b[i] <= 32'hA500_0000 | 32'(i);
            end
            mem_a[16] <= 32'hDEAD_BEEF;
            mem_a[32] <= 32'hCAFE_F00D;
            mem_a[48] <= 32'h0BAD_C0DE;
            mem_b[16] <= 32'hDEAD_BEEF;
            init_done <= 1'b1;
        end else begin
            if (m_en && m_we) mem_a[m_addr[7:0]] <= m_wdata;
            if (b_m_en && b_m_we) mem_b[b_m_addr[7:0]] <= b_m_wdata;
        end
        rd_a <= m_en ? mem_a[m_addr[7:0]] : 32'hBAD0_BAD0;
        pb0  <= b_m_en ? mem_b[b_m_addr[7:0]] : 32'hBAD0_BAD0;
        pb1  <= pb0;
        pb2  <= pb1;
    end
    assign m_rdata   = rd_a;
    assign b_m_rdata = pb2;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        is_data;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        exp_t e;
        if (i_ack || d_ack) begin
            check("ack_onehot", 32'(i_ack & d_ack), 32'h0);
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'h0, i_ack, d_ack}, 32'h0);
            end else begin
                e = sb.pop_front();
                check("ack_owner", 32'(d_ack), 32'(e.is_data));
                if (e.is_data) check("d_rdata", d_rdata, e.rdata);
                else           check("i_rdata", i_rdata, e.rdata);
            end
        end
    end

    task automatic wait_ack(input bit data, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(data ? d_ack : i_ack) && n < 50);
        if (!(data ? d_ack : i_ack)) check(name, 32'(data ? d_ack : i_ack), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen, en_at, ack_at;
        bit saw_ack;
        rst = 1'b1;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        b_i_req = 0; b_i_addr = 0;
        repeat (3) @(negedge clk);

        check("rst_i_ack", 32'(i_ack), 0);
        check("rst_d_ack", 32'(d_ack), 0);
        check("rst_m_en", 32'(m_en), 0);
        check("rst_m_we", 32'(m_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_m_addr", 32'(m_addr), 0);
        check("rst_m_wdata", m_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Lone fetch
        i_addr = 32'h40; i_req = 1'b1;
        sb.push_back('{1'b0, 32'hDEAD_BEEF});
        @(negedge clk);
        check("fetch_m_en", 32'(m_en), 1);
        check("fetch_m_we", 32'(m_we), 0);
        check("fetch_m_addr", 32'(m_addr), 32'h10);
        check("fetch_busy", 32'(busy), 1);
        @(negedge clk);
        check("fetch_m_en_one_cycle", 32'(m_en), 0);
        check("fetch_ack_early", 32'(i_ack), 0);
        @(negedge clk);
        check("fetch_ack_latency", 32'(i_ack), 1);
        check("fetch_no_d_ack", 32'(d_ack), 0);
        i_req = 1'b0;
        @(negedge clk);
        check("fetch_idle", 32'(busy), 0);

        // Store then load
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234_5678; d_req = 1'b1;
        sb.push_back('{1'b1, 32'h0});
        @(negedge clk);
        check("store_m_en", 32'(m_en), 1);
        check("store_m_we", 32'(m_we), 1);
        check("store_m_addr", 32'(m_addr), 32'h40);
        check("store_m_wdata", m_wdata, 32'h1234_5678);
        d_wdata = 32'hFFFF_FFFF; d_addr = 32'h200;
        wait_ack(1'b1, "store_ack_timeout");
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        d_addr = 32'h100; d_req = 1'b1;
        sb.push_back('{1'b1, 32'h1234_5678});
        @(negedge clk);
        check("load_m_we", 32'(m_we), 0);
        check("load_m_addr", 32'(m_addr), 32'h40);
        wait_ack(1'b1, "load_ack_timeout");
        d_req = 1'b0;
        @(negedge clk);

        // Simultaneous requests: data first, fetch right after
        i_addr = 32'h80; d_addr = 32'hC0; d_we = 1'b0;
        sb.push_back('{1'b1, 32'h0BAD_C0DE});
        sb.push_back('{1'b0, 32'hCAFE_F00D});
        i_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        check("simul_data_first", 32'(m_addr), 32'h30);
        wait_ack(1'b1, "simul_d_ack_timeout");
        d_req = 1'b0;
        @(negedge clk);
        check("simul_idle_gap", 32'(busy), 0);
        @(negedge clk);
        check("simul_fetch_m_en", 32'(m_en), 1);
        check("simul_fetch_m_addr", 32'(m_addr), 32'h20);
        wait_ack(1'b0, "simul_i_ack_timeout");
        i_req = 1'b0;
        @(negedge clk);
        check("d_rdata_held", d_rdata, 32'h0BAD_C0DE);

        // Starvation limit: D,D,D,D,I,D,D,D,D,I
        i_addr = 32'h40; d_addr = 32'h100;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) sb.push_back('{1'b1, 32'h1234_5678});
            sb.push_back('{1'b0, 32'hDEAD_BEEF});
        end
        i_req = 1'b1; d_req = 1'b1;
        seen = 0; n = 0;
        while (seen < 10 && n < 200) begin
            @(negedge clk);
            n++;
            if (i_ack || d_ack) seen++;
        end
        i_req = 1'b0; d_req = 1'b0;
        if (seen < 10) check("streak_ack_count", 32'(seen), 32'd10);
        repeat (2) @(negedge clk);
        check("streak_idle", 32'(busy), 0);
        check("streak_sb_drained", 32'(sb.size()), 0);

        // Reset during WAIT of a load
        d_addr = 32'h100; d_we = 1'b0; d_req = 1'b1;
        @(negedge clk);
        check("abort_issue", 32'(m_en), 1);
        @(negedge clk);
        rst = 1'b1;
        d_req = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_m_en", 32'(m_en), 0);
        check("abort_d_ack", 32'(d_ack), 0);
        check("abort_d_rdata", d_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (d_ack) saw_ack = 1'b1;
        end
        check("abort_no_ack", 32'(saw_ack), 0);
        d_req = 1'b1;
        sb.push_back('{1'b1, 32'h1234_5678});
        wait_ack(1'b1, "reissue_ack_timeout");
        d_req = 1'b0;
        @(negedge clk);

        // MEM_LAT=3 fetch latency
        b_i_addr = 32'h40; b_i_req = 1'b1;
        n = 0; en_at = 0; ack_at = 0;
        while (ack_at == 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (b_m_en && en_at == 0) en_at = n;
            if (b_i_ack) ack_at = n;
        end
        b_i_req = 1'b0;
        check("lat3_m_en_cycle", 32'(en_at), 32'd1);
        check("lat3_ack_cycle", 32'(ack_at), 32'd5);
        check("lat3_i_rdata", b_i_rdata, 32'hDEAD_BEEF);
        check("lat3_no_d_ack", 32'(b_d_ack), 0);

        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
